// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 3-sample majority vote) feeding a small byte FIFO.
// Serial line is resynchronised by two flops; every decision uses the synchronised copy.
module uart_rx_fifo #(
    parameter int clk_freq   = 100_000,
    parameter int baudrate   = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int BIT_CLKS = clk_freq / baudrate;
    localparam int H        = BIT_CLKS / 2;
    localparam int CW       = $clog2(BIT_CLKS);
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int NW       = PW + 1;

    localparam logic [CW-1:0] C_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] C_S0   = CW'(H - 1);
    localparam logic [CW-1:0] C_S1   = CW'(H);
    localparam logic [CW-1:0] C_S2   = CW'(H + 1);
    localparam logic [NW-1:0] N_FULL = NW'(FIFO_DEPTH);

    generate
        if (BIT_CLKS < 4) begin : g_bad_baud
            $error("clk_freq/baudrate must be at least 4");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                       s1_q, s2_q, rxs, rxs_prev_q;
    state_t                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0]                 idx_q, idx_d;
    logic [2:0]                 smp_q, smp_d;
    logic [7:0]                 shreg_q, shreg_d;
    logic                       maj, push_req;
    logic                       frame_err_q, frame_err_d;
    logic                       overrun_q, overrun_d;
    logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]              count_q, count_d;
    logic                       push, pop, full;

    assign rxs = s2_q;

    always_comb begin
        // The current sample is folded in so the vote is complete even when h+1 is the last count.
        smp_d = smp_q;
        if (cnt_q == C_S0) smp_d[0] = rxs;
        if (cnt_q == C_S1) smp_d[1] = rxs;
        if (cnt_q == C_S2) smp_d[2] = rxs;
        maj = (smp_d[0] & smp_d[1]) | (smp_d[0] & smp_d[2]) | (smp_d[1] & smp_d[2]);

        state_d     = state_q;
        cnt_d       = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs) begin
                    state_d = START;
                    idx_d   = '0;
                end
            end
            START: begin
                if (cnt_q == C_LAST) state_d = maj ? IDLE : DATA;
            end
            DATA: begin
                if (cnt_q == C_LAST) begin
                    shreg_d[idx_q] = maj;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                // Leave mid stop bit so the next start edge is caught early.
                if (cnt_q == C_S2) begin
                    state_d     = IDLE;
                    push_req    = maj;
                    frame_err_d = !maj;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full      = (count_q == N_FULL);
        pop       = (count_q != '0) && rx_ready;
        push      = push_req && (!full || pop);
        overrun_d = push_req && full && !pop;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = shreg_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + NW'(1);
        else if (!push && pop) count_d = count_q - NW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            smp_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            s1_q        <= rx;
            s2_q        <= s1_q;
            rxs_prev_q  <= rxs;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            smp_q       <= smp_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign rx_valid  = (count_q != '0);
    assign rx_data   = mem_q[rd_ptr_q];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes, a negedge monitor
// pops and compares on every accepted byte and tallies flag pulses.
module tb_uart_rx_fifo;
    localparam int BC = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.clk_freq(100_000), .baudrate(9600), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) check("unexpected_pop", rx_data, -1);
                else check("pop_data", rx_data, exp_q.pop_front());
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (busy) busy_cnt++;
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] frm;
        frm = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frm[i];
            idle(BC);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        idle(2);
    endtask

    initial begin
        int c0, fe0, ov0;
        logic [9:0] frm;

        // reset values
        idle(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(5);

        // single good byte, latency from frame start to rx_valid
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        c0 = cyc;
        send(8'hA5, 1'b1);
        idle(5);
        check("a5_latency_ok", (rise_cyc - c0 >= 98) && (rise_cyc - c0 <= 102), 1);
        drain("a5");
        check("a5_fe", fe_cnt - fe0, 0);
        check("a5_ov", ov_cnt - ov0, 0);

        // false start: 3 clk low glitch
        busy_cnt = 0; fe0 = fe_cnt; ov0 = ov_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        check("false_busy_cycles", busy_cnt, 10);
        check("false_no_push", rx_valid, 0);
        check("false_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        // bad stop bit, then a good frame after a full idle bit
        fe0 = fe_cnt;
        send(8'h3C, 1'b0);
        rx = 1'b1;
        idle(15);
        check("bad_stop_fe", fe_cnt - fe0, 1);
        check("bad_stop_no_push", rx_valid, 0);
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1);
        idle(10);
        drain("after_fe");

        // overrun with consumer stalled
        rx_ready = 1'b0; ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send(8'(i), 1'b1);
        end
        idle(10);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_head", rx_data, 8'h01);
        idle(20);
        check("ovr_head_stable", rx_data, 8'h01);
        rx_ready = 1'b1;
        drain("ovr");
        check("ovr_empty", rx_valid, 0);

        // full FIFO with a pop on the exact push cycle
        rx_ready = 1'b0; ov0 = ov_cnt;
        exp_q.push_back(8'h11); send(8'h11, 1'b1);
        exp_q.push_back(8'h22); send(8'h22, 1'b1);
        exp_q.push_back(8'h33); send(8'h33, 1'b1);
        exp_q.push_back(8'h44); send(8'h44, 1'b1);
        exp_q.push_back(8'h55);
        fork
            send(8'h55, 1'b1);
            begin
                repeat (99) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(10);
        check("simul_no_ovr", ov_cnt - ov0, 0);
        check("simul_left", exp_q.size(), 4);
        check("simul_head", rx_data, 8'h22);
        rx_ready = 1'b1;
        drain("simul");
        check("simul_empty", rx_valid, 0);

        // reset during data bit 4 with one byte buffered
        rx_ready = 1'b0;
        send(8'h77, 1'b1);
        idle(5);
        check("pre_rst_valid", rx_valid, 1);
        frm = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = frm[i];
            idle(BC);
        end
        rx = frm[5];
        idle(5);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        rx = 1'b1;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_flags", {frame_err, overrun}, 0);
        exp_q.delete();
        idle(3);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        idle(5);
        exp_q.push_back(8'hF0);
        send(8'hF0, 1'b1);
        idle(10);
        drain("post_rst");
        check("post_rst_empty", rx_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, expected to finish");
        $fatal(1, "watchdog");
    end
endmodule
